// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the multicycle controller: opcode
//                constants, FSM state and instruction-class enums, output
//                encodings (aluop, memtoreg, pc_src, cause) and the per-state
//                output decode used to load the registered control outputs.
//                The class CLS_BR is only produced when BRANCH_EN is defined.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcode field values
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;

    // aluop encodings
    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_BR  = 2'b01;
    localparam logic [1:0] c_ALU_R   = 2'b10;
    localparam logic [1:0] c_ALU_I   = 2'b11;

    // memtoreg encodings
    localparam logic [1:0] c_WB_ALU  = 2'b00;
    localparam logic [1:0] c_WB_MEM  = 2'b01;
    localparam logic [1:0] c_WB_PC4  = 2'b10;

    // pc_src encodings
    localparam logic [1:0] c_PC_PLUS4 = 2'b00;
    localparam logic [1:0] c_PC_BR    = 2'b01;
    localparam logic [1:0] c_PC_ALU   = 2'b10;

    // trap cause encodings
    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_ILL  = 2'b01;
    localparam logic [1:0] c_CAUSE_TMO  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_I    = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_JALR = 3'd4,
        CLS_BR   = 3'd5,
        CLS_ILL  = 3'd6
    } cls_t;

    // Registered control word. The fetch/pc_wr_* bits are enables that the top
    // level qualifies with mem_ready or zero in the cycle they apply.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       fetch;
        logic       pc_wr_jalr;
        logic       pc_wr_br;
        logic [1:0] pc_src;
        logic [1:0] memtoreg;
        logic [1:0] aluop;
        logic       alusrc;
        logic       regwr;
    } ctrl_out_t;

    // Control word for a state given the latched instruction class.
    function automatic ctrl_out_t state_outputs(input state_t st, input cls_t cls);
        ctrl_out_t o;
        o = '0;
        case (st)
            ST_FETCH: begin
                o.mem_req = 1'b1;
                o.fetch   = 1'b1;
                o.pc_src  = c_PC_PLUS4;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R: begin
                        o.aluop = c_ALU_R;
                    end
                    CLS_I: begin
                        o.aluop  = c_ALU_I;
                        o.alusrc = 1'b1;
                    end
                    CLS_LW, CLS_SW: begin
                        o.aluop  = c_ALU_ADD;
                        o.alusrc = 1'b1;
                    end
                    CLS_JALR: begin
                        o.aluop      = c_ALU_ADD;
                        o.alusrc     = 1'b1;
                        o.pc_wr_jalr = 1'b1;
                        o.pc_src     = c_PC_ALU;
                    end
                    CLS_BR: begin
                        o.aluop    = c_ALU_BR;
                        o.pc_wr_br = 1'b1;
                        o.pc_src   = c_PC_BR;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                o.mem_req = 1'b1;
                o.mem_we  = (cls == CLS_SW);
            end
            ST_WB: begin
                o.regwr = 1'b1;
                if (cls == CLS_LW) begin
                    o.memtoreg = c_WB_MEM;
                end else if (cls == CLS_JALR) begin
                    o.memtoreg = c_WB_PC4;
                end else begin
                    o.memtoreg = c_WB_ALU;
                end
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational opcode classifier. Maps the 7-bit opcode to an
//                instruction class and a legality flag. The branch opcode is
//                recognised only when BRANCH_EN is defined; otherwise it is
//                reported as illegal.
//  Ports       : i_opcode [6:0] - opcode field
//                o_cls          - decoded instruction class
//                o_legal        - 1 when the opcode is supported
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output cls_t       o_cls,
    output logic       o_legal
);

    always_comb begin
        o_cls = CLS_ILL;
        case (i_opcode)
            c_OP_R:    o_cls = CLS_R;
            c_OP_I:    o_cls = CLS_I;
            c_OP_LW:   o_cls = CLS_LW;
            c_OP_SW:   o_cls = CLS_SW;
            c_OP_JALR: o_cls = CLS_JALR;
`ifdef BRANCH_EN
            c_OP_BR:   o_cls = CLS_BR;
`endif
            default:   o_cls = CLS_ILL;
        endcase
    end

    assign o_legal = (o_cls != CLS_ILL);

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multicycle CPU control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/
//                TRAP) with a memory wait-timeout and a sticky trap flag.
//                Define BRANCH_EN to support the conditional branch opcode;
//                without it that opcode traps as illegal.
//  Parameters  : WAIT_MAX - cycles a memory request may wait (0 = no timeout)
//                ALUOP_W  - width of aluop
//  Ports       : clk, rst_n (async, active-low)
//                opcode[6:0], mem_ready, zero           - inputs
//                mem_req, mem_we, ir_wr, pc_wr          - strobes
//                pc_src[1:0], memtoreg[1:0], aluop      - selects
//                alusrc, regwr                          - datapath controls
//                trap, cause[1:0]                       - fault status
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int ALUOP_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_src,
    output logic [1:0]         memtoreg,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrc,
    output logic               regwr,
    output logic               trap,
    output logic [1:0]         cause
);

    localparam int c_WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_next;
    cls_t                r_cls;
    cls_t                w_cls_next;
    cls_t                w_dec_cls;
    logic                w_dec_legal;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_wait_last;
    logic                w_mem_phase;
    ctrl_out_t           r_out;
    logic                r_trap;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_next;

    ctrl_decode u_decode (
        .i_opcode (opcode),
        .o_cls    (w_dec_cls),
        .o_legal  (w_dec_legal)
    );

    assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);
    // The cycle whose miss would bring the counter to WAIT_MAX; a ready in
    // this same cycle still completes the request.
    assign w_wait_last = (WAIT_MAX != 0) && (r_wait == c_WAIT_LAST);
    assign w_cls_next  = (r_state == ST_DECODE) ? w_dec_cls : r_cls;

    always_comb begin
        w_next       = r_state;
        w_cause_next = r_cause;
        case (r_state)
            ST_IDLE: w_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next = ST_DECODE;
                end else if (w_wait_last) begin
                    w_next       = ST_TRAP;
                    w_cause_next = c_CAUSE_TMO;
                end
            end
            ST_DECODE: begin
                if (!w_dec_legal) begin
                    w_next       = ST_TRAP;
                    w_cause_next = c_CAUSE_ILL;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_R, CLS_I, CLS_JALR: w_next = ST_WB;
                    CLS_LW, CLS_SW:         w_next = ST_MEM;
                    CLS_BR:                 w_next = ST_FETCH;
                    default: begin
                        w_next       = ST_TRAP;
                        w_cause_next = c_CAUSE_ILL;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_next = (r_cls == CLS_LW) ? ST_WB : ST_FETCH;
                end else if (w_wait_last) begin
                    w_next       = ST_TRAP;
                    w_cause_next = c_CAUSE_TMO;
                end
            end
            ST_WB:   w_next = ST_FETCH;
            ST_TRAP: w_next = ST_TRAP;
            default: w_next = ST_IDLE;
        endcase
    end

    // Control outputs are loaded with the word of the state being entered,
    // so they are glitch-free registers that clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cls   <= CLS_R;
            r_wait  <= '0;
            r_out   <= '0;
            r_trap  <= 1'b0;
            r_cause <= c_CAUSE_NONE;
        end else begin
            r_state <= w_next;
            r_cls   <= w_cls_next;
            r_out   <= state_outputs(w_next, w_cls_next);
            r_trap  <= (w_next == ST_TRAP);
            r_cause <= w_cause_next;
            if ((w_next != r_state) && ((w_next == ST_FETCH) || (w_next == ST_MEM))) begin
                r_wait <= '0;
            end else if (w_mem_phase && !mem_ready) begin
                r_wait <= r_wait + c_WAIT_W'(1);
            end
        end
    end

    assign mem_req  = r_out.mem_req;
    assign mem_we   = r_out.mem_we;
    assign ir_wr    = r_out.fetch & mem_ready;
    assign pc_wr    = (r_out.fetch & mem_ready) | r_out.pc_wr_jalr | (r_out.pc_wr_br & zero);
    assign pc_src   = r_out.pc_src;
    assign memtoreg = r_out.memtoreg;
    assign aluop    = ALUOP_W'(r_out.aluop);
    assign alusrc   = r_out.alusrc;
    assign regwr    = r_out.regwr;
    assign trap     = r_trap;
    assign cause    = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Directed self-checking bench for multicycle_controller.
//                Expected control words are queued as each step is driven and
//                popped when the DUT outputs are sampled. Branch checks follow
//                BRANCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       mem_req, mem_we, ir_wr, pc_wr, alusrc, regwr, trap;
    logic [1:0] pc_src, memtoreg, aluop, cause;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [14:0] v;
    } exp_t;
    exp_t sb[$];

    multicycle_controller #(.WAIT_MAX(15), .ALUOP_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .zero      (zero),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_wr     (ir_wr),
        .pc_wr     (pc_wr),
        .pc_src    (pc_src),
        .memtoreg  (memtoreg),
        .aluop     (aluop),
        .alusrc    (alusrc),
        .regwr     (regwr),
        .trap      (trap),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_we,ir_wr,pc_wr,pc_src,memtoreg,aluop,alusrc,regwr,trap,cause}
    function automatic logic [14:0] ov(input logic mr, input logic mw, input logic ir,
                                       input logic pw, input logic [1:0] ps,
                                       input logic [1:0] mt, input logic [1:0] ao,
                                       input logic as, input logic rw, input logic tr,
                                       input logic [1:0] ca);
        return {mr, mw, ir, pw, ps, mt, ao, as, rw, tr, ca};
    endfunction

    localparam logic [14:0] E_ZERO   = 15'd0;
    logic [14:0] e_fetch_w, e_fetch_r, e_ex_r, e_ex_i, e_ex_ls, e_ex_jalr;
    logic [14:0] e_mem_lw, e_mem_sw, e_wb_alu, e_wb_mem, e_wb_pc4;
    logic [14:0] e_trap_ill, e_trap_tmo;

    function automatic logic [14:0] observed();
        return {mem_req, mem_we, ir_wr, pc_wr, pc_src, memtoreg, aluop, alusrc, regwr, trap, cause};
    endfunction

    task automatic compare_head();
        exp_t        e;
        logic [14:0] o;
        e = sb.pop_front();
        o = observed();
        total++;
        assert (o === e.v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.v);
        end
    endtask

    // Queue the expectation, sample mid-cycle, then advance past the next edge.
    task automatic step(input string tag, input logic [14:0] v);
        sb.push_back('{tag, v});
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    // Check immediately, without a clock edge (asynchronous behaviour).
    task automatic check_now(input string tag, input logic [14:0] v);
        sb.push_back('{tag, v});
        #1;
        compare_head();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        check_now("rst_async", E_ZERO);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        e_fetch_w  = ov(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        e_fetch_r  = ov(1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        e_ex_r     = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 2'b00);
        e_ex_i     = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 2'b00);
        e_ex_ls    = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00);
        e_ex_jalr  = ov(0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b00);
        e_mem_lw   = ov(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        e_mem_sw   = ov(1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00);
        e_wb_alu   = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00);
        e_wb_mem   = ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 1, 0, 2'b00);
        e_wb_pc4   = ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 1, 0, 2'b00);
        e_trap_ill = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b01);
        e_trap_tmo = ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b10);

        // Reset state, then leave reset
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        step("reset_hold", E_ZERO);
        rst_n = 1'b1;
        step("idle", E_ZERO);

        // R-type with zero-wait memory: 4 cycles, regwr only in the last
        opcode = 7'b0110011;
        step("r_fetch", e_fetch_r);
        step("r_decode", E_ZERO);
        step("r_exec", e_ex_r);
        step("r_wb", e_wb_alu);

        // I-type ALU
        opcode = 7'b0010011;
        step("i_fetch", e_fetch_r);
        step("i_decode", E_ZERO);
        step("i_exec", e_ex_i);
        step("i_wb", e_wb_alu);

        // LW with three wait cycles in MEM (ready high in EXEC is ignored)
        opcode = 7'b0000011;
        step("lw_fetch", e_fetch_r);
        step("lw_decode", E_ZERO);
        step("lw_exec", e_ex_ls);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", e_mem_lw);
        mem_ready = 1'b1;
        step("lw_mem_done", e_mem_lw);
        step("lw_wb", e_wb_mem);

        // SW: back to FETCH straight from MEM
        opcode = 7'b0100011;
        step("sw_fetch", e_fetch_r);
        step("sw_decode", E_ZERO);
        step("sw_exec", e_ex_ls);
        step("sw_mem", e_mem_sw);

        // JALR
        opcode = 7'b1100111;
        step("jalr_fetch", e_fetch_r);
        step("jalr_decode", E_ZERO);
        step("jalr_exec", e_ex_jalr);
        step("jalr_wb", e_wb_pc4);

        // Ready arriving in the 15th FETCH cycle wins over the timeout
        opcode = 7'b0100011;
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) step("fetch_wait", e_fetch_w);
        mem_ready = 1'b1;
        step("fetch_ready_15", e_fetch_r);
        step("sw2_decode", E_ZERO);
        step("sw2_exec", e_ex_ls);
        mem_ready = 1'b0;
        step("sw2_mem_wait", e_mem_sw);

        // Reset in the middle of the SW memory request
        do_reset();
        step("post_rst_idle", E_ZERO);
        step("post_rst_fetch", e_fetch_w);

        // Illegal opcode: sticky trap with cause 01
        opcode = 7'b1111111;
        mem_ready = 1'b1;
        step("ill_fetch", e_fetch_r);
        step("ill_decode", E_ZERO);
        for (int i = 0; i < 4; i++) step("ill_trap", e_trap_ill);

        // Fetch timeout: 15 idle cycles then trap with cause 10
        do_reset();
        mem_ready = 1'b0;
        step("tmo_idle", E_ZERO);
        for (int i = 0; i < 15; i++) step("tmo_fetch", e_fetch_w);
        mem_ready = 1'b1;
        step("tmo_trap", e_trap_tmo);
        step("tmo_trap_hold", e_trap_tmo);

        // Branch opcode
        do_reset();
        opcode = 7'b1100011;
        step("br_idle", E_ZERO);
`ifdef BRANCH_EN
        zero = 1'b1;
        step("br_fetch", e_fetch_r);
        step("br_decode", E_ZERO);
        step("br_exec_taken", ov(0, 0, 0, 1, 2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b00));
        zero = 1'b0;
        step("br2_fetch", e_fetch_r);
        step("br2_decode", E_ZERO);
        step("br_exec_not_taken", ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b00));
        mem_ready = 1'b0;
        step("br_next_fetch", e_fetch_w);
`else
        zero = 1'b1;
        step("br_fetch", e_fetch_r);
        step("br_decode", E_ZERO);
        step("br_illegal_trap", e_trap_ill);
        step("br_trap_hold", e_trap_ill);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, max cycles a memory request waits for mem_ready; 0 disables the timeout.
REQ-002 SHALL have parameter ALUOP_W, default 2, width of aluop.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  7  instruction opcode field from the instruction register.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 zero  input  1  ALU compare result for branch evaluation.
REQ-008 mem_req / mem_we  output  1 each  memory request; write qualifier.
REQ-009 ir_wr / pc_wr  output  1 each  instruction-register load; PC load.
REQ-010 pc_src  output  2  PC source: 00 PC+4, 01 branch target, 10 ALU result.
REQ-011 memtoreg  output  2  write-back source: 00 ALU, 01 memory, 10 PC+4.
REQ-012 aluop  output  ALUOP_W  00 add, 01 branch compare, 10 R-type, 11 I-type ALU.
REQ-013 alusrc / regwr  output  1 each  immediate operand select; register-file write.
REQ-014 trap  output  1  sticky fault flag.
REQ-015 cause  output  2  01 illegal opcode, 10 memory timeout, 00 none.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-017 IDLE: all outputs 0; next state FETCH.
REQ-018 FETCH: mem_req=1; on mem_ready, ir_wr=1, pc_wr=1, pc_src=00, go DECODE; else hold.
REQ-019 DECODE: latch opcode class; unsupported opcode -> TRAP, cause=01; else EXEC.
REQ-020 EXEC R-type (0110011): aluop=10, alusrc=0 -> WB, memtoreg=00.
REQ-021 EXEC I-ALU (0010011): aluop=11, alusrc=1 -> WB, memtoreg=00.
REQ-022 EXEC LW (0000011) / SW (0100011): aluop=00, alusrc=1 -> MEM.
REQ-023 EXEC JALR (1100111): aluop=00, alusrc=1, pc_wr=1, pc_src=10 -> WB, memtoreg=10.
REQ-024 EXEC branch (1100011): aluop=01, alusrc=0; pc_wr=zero, pc_src=01 -> FETCH.
REQ-025 MEM: mem_req=1, mem_we=1 for SW only; on mem_ready, LW -> WB (memtoreg=01), SW -> FETCH.
REQ-026 WB: regwr=1 for exactly one cycle, memtoreg per latched class -> FETCH.
REQ-027 Outputs not listed for a state SHALL be 0.
REQ-028 Wait counter SHALL clear on entering FETCH or MEM and increment each cycle mem_ready=0; reaching WAIT_MAX -> TRAP, cause=10.
REQ-029 mem_ready in the cycle the counter reaches WAIT_MAX SHALL win; no timeout.
REQ-030 TRAP: trap=1, cause held, all other outputs 0, exit only by reset.
REQ-031 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-032 Latency: R/I 4 cycles, LW 5, SW 4, JALR 4, branch 3, each with zero-wait memory.

Reset
REQ-033 rst_n low SHALL force IDLE, counter 0, trap=0, cause=00, all outputs 0, immediately and regardless of clock.
REQ-034 Reset mid-request SHALL drop mem_req asynchronously; no retry.

Configuration
REQ-035 With BRANCH_EN defined, opcode 1100011 SHALL decode per REQ-024.
REQ-036 Without BRANCH_EN, 1100011 SHALL be illegal (TRAP, cause=01), pc_src=01 never driven.

Structure
REQ-037 Package ctrl_pkg SHALL hold opcode constants, state enum, aluop/memtoreg/pc_src/cause encodings.
REQ-038 Sub-module ctrl_decode SHALL map opcode to instruction class and legality, combinationally.

Verification
REQ-039 R-type 0110011, mem_ready=1 always -> FETCH,DECODE,EXEC,WB; regwr=1 only in cycle 4, aluop=10.
REQ-040 LW, mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, mem_we=0, then WB, memtoreg=01.
REQ-041 BRANCH_EN, branch with zero=1 -> pc_wr=1, pc_src=01 in EXEC; with zero=0 -> pc_wr=0; next FETCH.
REQ-042 Opcode 1111111 -> TRAP after DECODE, trap=1, cause=01, stays until rst_n low.
REQ-043 WAIT_MAX=15, mem_ready never high in FETCH -> TRAP after 15 cycles, cause=10; ready on cycle 15 -> DECODE.
REQ-044 rst_n low during MEM of SW -> mem_req, mem_we 0 same cycle; after release IDLE then FETCH.
